// File: rtl/vai_rx_router.sv
// Rx-direction router for the virtual-AFU mux: steers c0/c1 responses and MMIO requests to sub-AFU ports.
// Optional per-port outstanding-line counters are compiled in with `define VAI_RX_ROUTER_CNT_EN.

package vai_ccip_pkg;
  localparam int CL_DATA_W = 512;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  // MMIO header shares the c0 header bits; address sits in the top 16 bits.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr    hdr;
    logic [CL_DATA_W-1:0]  data;
    logic                  rspValid;
    logic                  mmioRdValid;
    logic                  mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module vai_rx_router
  import vai_ccip_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 9,
  parameter int IDX_W        = 4,
  parameter int CNT_W        = 10
) (
  input  logic               pClk,
  input  logic               SoftReset,
  input  t_if_ccip_Rx        up_RxPort,
  output t_if_ccip_Rx        afu_RxPort [NUM_SUB_AFUS],
  input  logic               rd_issue_valid,
  input  logic [IDX_W-1:0]   rd_issue_idx,
  input  logic [2:0]         rd_issue_lines,
  input  logic               wr_issue_valid,
  input  logic [IDX_W-1:0]   wr_issue_idx,
  input  logic [2:0]         wr_issue_lines,
  output logic [CNT_W-1:0]   outstanding [NUM_SUB_AFUS],
  output logic               err_unmapped,
  output logic               err_cnt
);

  t_ccip_c0_RspMemHdr  c0_hdr_fwd;
  t_ccip_c1_RspMemHdr  c1_hdr_fwd;
  t_ccip_c0_ReqMmioHdr mmio_hdr;
  logic [IDX_W-1:0]    c0_idx, mmio_idx, c1_idx;
  logic                c0_mmio;
  logic                unmapped;
  logic [NUM_SUB_AFUS-1:0] c0_rsp_hit, mmio_rd_hit, mmio_wr_hit, c1_rsp_hit;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    c0_hdr_fwd = up_RxPort.c0.hdr;
    c1_hdr_fwd = up_RxPort.c1.hdr;
    mmio_hdr   = t_ccip_c0_ReqMmioHdr'(up_RxPort.c0.hdr);
    c0_idx     = up_RxPort.c0.hdr.mdata[12 +: IDX_W];
    mmio_idx   = mmio_hdr.address[12 +: IDX_W];
    c1_idx     = up_RxPort.c1.hdr.mdata[12 +: IDX_W];
    c0_mmio    = up_RxPort.c0.mmioRdValid | up_RxPort.c0.mmioWrValid;

    if (up_RxPort.c0.rspValid) c0_hdr_fwd.mdata[12 +: IDX_W] = '0;
    if (c0_mmio) begin
      mmio_hdr.address[12 +: IDX_W] = '0;
      c0_hdr_fwd = t_ccip_c0_RspMemHdr'(mmio_hdr);
    end
    if (up_RxPort.c1.rspValid) c1_hdr_fwd.mdata[12 +: IDX_W] = '0;

    for (int p = 0; p < NUM_SUB_AFUS; p++) begin
      c0_rsp_hit[p]  = up_RxPort.c0.rspValid    && (c0_idx   == IDX_W'(p));
      mmio_rd_hit[p] = up_RxPort.c0.mmioRdValid && (mmio_idx == IDX_W'(p));
      mmio_wr_hit[p] = up_RxPort.c0.mmioWrValid && (mmio_idx == IDX_W'(p));
      c1_rsp_hit[p]  = up_RxPort.c1.rspValid    && (c1_idx   == IDX_W'(p));
    end

    unmapped = (up_RxPort.c0.rspValid && int'(c0_idx)   >= NUM_SUB_AFUS) ||
               (c0_mmio               && int'(mmio_idx) >= NUM_SUB_AFUS) ||
               (up_RxPort.c1.rspValid && int'(c1_idx)   >= NUM_SUB_AFUS);
  end

  t_ccip_c0_RspMemHdr      c0_hdr_q;
  logic [CL_DATA_W-1:0]    c0_data_q;
  t_ccip_c1_RspMemHdr      c1_hdr_q;
  logic [NUM_SUB_AFUS-1:0] c0_rsp_q, mmio_rd_q, mmio_wr_q, c1_rsp_q;
  logic                    c0_alm_q, c1_alm_q;

  // NOTE: payload registers have no reset; only the valids qualify them, so resetting
  // the wide datapath would buy nothing.
  always_ff @(posedge pClk) begin
    c0_hdr_q  <= c0_hdr_fwd;
    c0_data_q <= up_RxPort.c0.data;
    c1_hdr_q  <= c1_hdr_fwd;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      c0_rsp_q     <= '0;
      mmio_rd_q    <= '0;
      mmio_wr_q    <= '0;
      c1_rsp_q     <= '0;
      c0_alm_q     <= 1'b1;
      c1_alm_q     <= 1'b1;
      err_unmapped <= 1'b0;
    end else begin
      c0_rsp_q     <= c0_rsp_hit;
      mmio_rd_q    <= mmio_rd_hit;
      mmio_wr_q    <= mmio_wr_hit;
      c1_rsp_q     <= c1_rsp_hit;
      c0_alm_q     <= up_RxPort.c0TxAlmFull;
      c1_alm_q     <= up_RxPort.c1TxAlmFull;
      err_unmapped <= err_unmapped | unmapped;
    end
  end

  // One registered payload copy fans out to every port; only the valids are per port.
  always_comb begin
    for (int p = 0; p < NUM_SUB_AFUS; p++) begin
      afu_RxPort[p].c0TxAlmFull    = c0_alm_q;
      afu_RxPort[p].c1TxAlmFull    = c1_alm_q;
      afu_RxPort[p].c0.hdr         = c0_hdr_q;
      afu_RxPort[p].c0.data        = c0_data_q;
      afu_RxPort[p].c0.rspValid    = c0_rsp_q[p];
      afu_RxPort[p].c0.mmioRdValid = mmio_rd_q[p];
      afu_RxPort[p].c0.mmioWrValid = mmio_wr_q[p];
      afu_RxPort[p].c1.hdr         = c1_hdr_q;
      afu_RxPort[p].c1.rspValid    = c1_rsp_q[p];
    end
  end

`ifdef VAI_RX_ROUTER_CNT_EN
  localparam int SUM_W = CNT_W + 2;
  typedef logic signed [SUM_W-1:0] t_sum;
  localparam t_sum CNT_MAX = t_sum'({2'b00, {CNT_W{1'b1}}});

  logic [2:0]              c1_dec;
  logic [CNT_W-1:0]        cnt_next [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] cnt_bad;
  t_sum                    sum;

  // All four events on a port fold into one signed sum, then clamp.
  always_comb begin
    c1_dec = up_RxPort.c1.hdr.format ? ({1'b0, up_RxPort.c1.hdr.cl_num} + 3'd1) : 3'd1;
    sum    = '0;
    for (int p = 0; p < NUM_SUB_AFUS; p++) begin
      sum = t_sum'({2'b00, outstanding[p]});
      if (rd_issue_valid && rd_issue_idx == IDX_W'(p))
        sum = sum + t_sum'({{(SUM_W-3){1'b0}}, rd_issue_lines});
      if (wr_issue_valid && wr_issue_idx == IDX_W'(p))
        sum = sum + t_sum'({{(SUM_W-3){1'b0}}, wr_issue_lines});
      if (c0_rsp_hit[p]) sum = sum - t_sum'(1);
      if (c1_rsp_hit[p]) sum = sum - t_sum'({{(SUM_W-3){1'b0}}, c1_dec});
      cnt_bad[p] = 1'b0;
      if (sum < 0) begin
        cnt_next[p] = '0;
        cnt_bad[p]  = 1'b1;
      end else if (sum > CNT_MAX) begin
        cnt_next[p] = '1;
        cnt_bad[p]  = 1'b1;
      end else begin
        cnt_next[p] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      for (int p = 0; p < NUM_SUB_AFUS; p++) outstanding[p] <= '0;
      err_cnt <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_SUB_AFUS; p++) outstanding[p] <= cnt_next[p];
      err_cnt <= err_cnt | (|cnt_bad);
    end
  end
`else
  logic unused_issue;
  assign unused_issue = ^{rd_issue_valid, rd_issue_idx, rd_issue_lines,
                          wr_issue_valid, wr_issue_idx, wr_issue_lines};

  always_comb begin
    for (int p = 0; p < NUM_SUB_AFUS; p++) outstanding[p] = '0;
    err_cnt = 1'b0;
  end
`endif

endmodule

// File: tb/tb_vai_rx_router.sv
// Self-checking bench for vai_rx_router: directed table, plan sequences, and random traffic
// against a spec-level model; counter expectations follow VAI_RX_ROUTER_CNT_EN.
`timescale 1ns/1ps
module tb_vai_rx_router;
  import vai_ccip_pkg::*;

  localparam int N       = 9;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef VAI_RX_ROUTER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int K_NONE = 0, K_RSP = 1, K_MRD = 2, K_MWR = 3;

  logic              pClk = 1'b0;
  logic              SoftReset;
  t_if_ccip_Rx       up_RxPort;
  t_if_ccip_Rx       afu_RxPort [N];
  logic              rd_issue_valid, wr_issue_valid;
  logic [IDX_W-1:0]  rd_issue_idx, wr_issue_idx;
  logic [2:0]        rd_issue_lines, wr_issue_lines;
  logic [CNT_W-1:0]  outstanding [N];
  logic              err_unmapped, err_cnt;

  always #5 pClk = ~pClk;

  vai_rx_router #(.NUM_SUB_AFUS(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .pClk(pClk), .SoftReset(SoftReset), .up_RxPort(up_RxPort), .afu_RxPort(afu_RxPort),
    .rd_issue_valid(rd_issue_valid), .rd_issue_idx(rd_issue_idx), .rd_issue_lines(rd_issue_lines),
    .wr_issue_valid(wr_issue_valid), .wr_issue_idx(wr_issue_idx), .wr_issue_lines(wr_issue_lines),
    .outstanding(outstanding), .err_unmapped(err_unmapped), .err_cnt(err_cnt)
  );

  typedef struct {
    int c0_kind; int c0_idx; logic [11:0] c0_low; logic [8:0] tid; logic [3:0] rt;
    logic [CL_DATA_W-1:0] data;
    bit c1_v; int c1_idx; logic [11:0] c1_low; bit c1_fmt; int c1_cl;
    bit alm0, alm1;
    bit rd_v; int rd_idx; int rd_lines;
    bit wr_v; int wr_idx; int wr_lines;
  } stim_t;

  typedef struct {
    stim_t in; int chan; int port; logic [15:0] field; bit unmapped;
  } vec_t;

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  function automatic logic [CL_DATA_W-1:0] rand_data();
    logic [CL_DATA_W-1:0] d;
    for (int i = 0; i < CL_DATA_W/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.data = rand_data();
    s.rt   = 4'($urandom());
    s.tid  = 9'($urandom());
    return s;
  endfunction

  function automatic stim_t ev_c0(int kind, int idx, logic [11:0] low, logic [8:0] tid);
    stim_t s = idle();
    s.c0_kind = kind; s.c0_idx = idx; s.c0_low = low; s.tid = tid;
    return s;
  endfunction

  function automatic stim_t ev_c1(int idx, logic [11:0] low, bit fmt, int cl);
    stim_t s = idle();
    s.c1_v = 1'b1; s.c1_idx = idx; s.c1_low = low; s.c1_fmt = fmt; s.c1_cl = cl;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    t_ccip_c0_ReqMmioHdr mh;
    up_RxPort = '0;
    up_RxPort.c0TxAlmFull = s.alm0;
    up_RxPort.c1TxAlmFull = s.alm1;
    up_RxPort.c0.data     = s.data;
    if (s.c0_kind == K_MRD || s.c0_kind == K_MWR) begin
      mh = '0;
      mh.address = {4'(s.c0_idx), s.c0_low};
      mh.length  = s.rt[1:0];
      mh.tid     = s.tid;
      up_RxPort.c0.hdr         = t_ccip_c0_RspMemHdr'(mh);
      up_RxPort.c0.mmioRdValid = (s.c0_kind == K_MRD);
      up_RxPort.c0.mmioWrValid = (s.c0_kind == K_MWR);
    end else begin
      up_RxPort.c0.hdr.mdata     = {4'(s.c0_idx), s.c0_low};
      up_RxPort.c0.hdr.resp_type = s.rt;
      up_RxPort.c0.hdr.cl_num    = s.tid[1:0];
      up_RxPort.c0.rspValid      = (s.c0_kind == K_RSP);
    end
    up_RxPort.c1.hdr.mdata     = {4'(s.c1_idx), s.c1_low};
    up_RxPort.c1.hdr.resp_type = s.rt;
    up_RxPort.c1.hdr.format    = s.c1_fmt;
    up_RxPort.c1.hdr.cl_num    = 2'(s.c1_cl);
    up_RxPort.c1.rspValid      = s.c1_v;
    rd_issue_valid = s.rd_v; rd_issue_idx = 4'(s.rd_idx); rd_issue_lines = 3'(s.rd_lines);
    wr_issue_valid = s.wr_v; wr_issue_idx = 4'(s.wr_idx); wr_issue_lines = 3'(s.wr_lines);
  endtask

  // Reference model state: expected outputs after the most recent clock edge.
  int                   m_cnt [N];
  bit                   m_err_un, m_err_cnt;
  logic [4*N-1:0]       exp_vec;
  logic [1:0]           exp_alm;
  int                   exp_c0_port, exp_c1_port;
  logic [27:0]          exp_c0_hdr, exp_c1_hdr;
  logic [CL_DATA_W-1:0] exp_data;

  function automatic void model_step(input stim_t s, input bit rst);
    int n;
    exp_vec = '0; exp_c0_port = -1; exp_c1_port = -1;
    if (rst) begin
      foreach (m_cnt[p]) m_cnt[p] = 0;
      m_err_un = 1'b0; m_err_cnt = 1'b0; exp_alm = 2'b11;
      return;
    end
    exp_alm = {s.alm0, s.alm1};
    if (s.c0_kind != K_NONE) begin
      if (s.c0_idx < N) begin
        exp_c0_port = s.c0_idx;
        exp_vec[(s.c0_kind-1)*N + s.c0_idx] = 1'b1;
      end else m_err_un = 1'b1;
    end
    // The index nibble is mdata[15:12] (hdr bits 15:12) or address[15:12] (hdr bits 27:24).
    exp_c0_hdr = (s.c0_kind == K_RSP) ? (up_RxPort.c0.hdr & ~28'h000F000)
                                      : (up_RxPort.c0.hdr & ~28'hF000000);
    exp_data   = s.data;
    if (s.c1_v) begin
      if (s.c1_idx < N) begin
        exp_c1_port = s.c1_idx;
        exp_vec[3*N + s.c1_idx] = 1'b1;
      end else m_err_un = 1'b1;
    end
    exp_c1_hdr = up_RxPort.c1.hdr & ~28'h000F000;
    if (CNT_EN) begin
      for (int p = 0; p < N; p++) begin
        n = m_cnt[p];
        if (s.rd_v && s.rd_idx == p) n += s.rd_lines;
        if (s.wr_v && s.wr_idx == p) n += s.wr_lines;
        if (s.c0_kind == K_RSP && s.c0_idx == p) n -= 1;
        if (s.c1_v && s.c1_idx == p) n -= s.c1_fmt ? s.c1_cl + 1 : 1;
        if (n < 0)       begin n = 0;       m_err_cnt = 1'b1; end
        if (n > CNT_MAX) begin n = CNT_MAX; m_err_cnt = 1'b1; end
        m_cnt[p] = n;
      end
    end
  endfunction

  task automatic compare();
    logic [4*N-1:0] act;
    logic [2*N-1:0] alm_act, alm_exp;
    for (int p = 0; p < N; p++) begin
      act[p]       = afu_RxPort[p].c0.rspValid;
      act[N+p]     = afu_RxPort[p].c0.mmioRdValid;
      act[2*N+p]   = afu_RxPort[p].c0.mmioWrValid;
      act[3*N+p]   = afu_RxPort[p].c1.rspValid;
      alm_act[2*p +: 2] = {afu_RxPort[p].c0TxAlmFull, afu_RxPort[p].c1TxAlmFull};
      alm_exp[2*p +: 2] = exp_alm;
    end
    check("valids", 64'(act), 64'(exp_vec));
    check("almfull", 64'(alm_act), 64'(alm_exp));
    if (exp_c0_port >= 0) begin
      check("c0_hdr", 64'(afu_RxPort[exp_c0_port].c0.hdr), 64'(exp_c0_hdr));
      check("c0_data_equal", 64'(afu_RxPort[exp_c0_port].c0.data == exp_data), 64'd1);
    end
    if (exp_c1_port >= 0) check("c1_hdr", 64'(afu_RxPort[exp_c1_port].c1.hdr), 64'(exp_c1_hdr));
    for (int p = 0; p < N; p++)
      check($sformatf("outstanding[%0d]", p), 64'(outstanding[p]), 64'(m_cnt[p]));
    check("err_unmapped", 64'(err_unmapped), 64'(m_err_un));
    check("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
  endtask

  task automatic cycle(input stim_t s, input bit rst);
    SoftReset = rst;
    drive(s);
    @(posedge pClk);
    #1;
    model_step(s, rst);
    compare();
  endtask

  // Two reset cycles with junk inputs, then release and check the first post-reset cycle.
  task automatic do_reset();
    stim_t s;
    for (int i = 0; i < 2; i++) begin
      s = ev_c0(K_RSP, 3, 12'h111, 9'h0);
      s.rd_v = 1'b1; s.rd_idx = 3; s.rd_lines = 4; s.c1_v = 1'b1; s.alm0 = 1'b0;
      cycle(s, 1'b1);
    end
    SoftReset = 1'b0;
    drive(idle());
    #1;
    compare();
  endtask

  function automatic int route_code();
    int code = 255;
    for (int p = 0; p < N; p++) begin
      if (afu_RxPort[p].c0.rspValid)    code = 0*16 + p;
      if (afu_RxPort[p].c0.mmioRdValid) code = 1*16 + p;
      if (afu_RxPort[p].c0.mmioWrValid) code = 2*16 + p;
      if (afu_RxPort[p].c1.rspValid)    code = 3*16 + p;
    end
    return code;
  endfunction

  initial begin
    vec_t                tbl [8];
    stim_t               s;
    t_ccip_c0_ReqMmioHdr mh;
    logic [15:0]         fld;

    tbl[0] = '{ev_c0(K_RSP, 3, 12'h0A5, 9'h000), 0, 3, 16'h00A5, 1'b0};
    tbl[1] = '{ev_c0(K_MRD, 8, 12'h010, 9'h01F), 1, 8, 16'h0010, 1'b0};
    tbl[2] = '{ev_c1(0, 12'hFFF, 1'b0, 0),        3, 0, 16'h0FFF, 1'b0};
    tbl[3] = '{ev_c0(K_MWR, 2, 12'hABC, 9'h155), 2, 2, 16'h0ABC, 1'b0};
    tbl[4] = '{ev_c0(K_MWR, 9, 12'h000, 9'h000), 2, -1, 16'h0000, 1'b1};
    tbl[5] = '{ev_c0(K_RSP, 7, 12'h555, 9'h000), 0, 7, 16'h0555, 1'b1};
    tbl[6] = '{ev_c1(12, 12'h321, 1'b1, 2),      3, -1, 16'h0000, 1'b1};
    tbl[7] = '{ev_c0(K_RSP, 0, 12'h000, 9'h000), 0, 0, 16'h0000, 1'b1};

    SoftReset = 1'b1;
    drive(idle());
    do_reset();

    // Packed write response retires all four lines.
    s = idle(); s.wr_v = 1'b1; s.wr_idx = 2; s.wr_lines = 4;
    cycle(s, 1'b0);
    check("packed_issue", 64'(outstanding[2]), CNT_EN ? 64'd4 : 64'd0);
    cycle(ev_c1(2, 12'h0C3, 1'b1, 3), 1'b0);
    check("packed_done", 64'(outstanding[2]), 64'd0);
    check("packed_no_err", 64'(err_cnt), 64'd0);

    // Issue, read response and single-line write response on one port in one cycle.
    s = idle(); s.rd_v = 1'b1; s.rd_idx = 5; s.rd_lines = 3;
    cycle(s, 1'b0);
    s = ev_c0(K_RSP, 5, 12'h077, 9'h0);
    s.rd_v = 1'b1; s.rd_idx = 5; s.rd_lines = 2;
    s.c1_v = 1'b1; s.c1_idx = 5; s.c1_low = 12'h088; s.c1_fmt = 1'b0; s.c1_cl = 3;
    cycle(s, 1'b0);
    check("simultaneous_net", 64'(outstanding[5]), CNT_EN ? 64'd3 : 64'd0);

    // Saturation: build port 4 up to 1021, then issue four more lines.
    for (int i = 0; i < 127; i++) begin
      s = idle(); s.rd_v = 1'b1; s.rd_idx = 4; s.rd_lines = 4;
      s.wr_v = 1'b1; s.wr_idx = 4; s.wr_lines = 4;
      cycle(s, 1'b0);
    end
    s = idle(); s.rd_v = 1'b1; s.rd_idx = 4; s.rd_lines = 4;
    s.wr_v = 1'b1; s.wr_idx = 4; s.wr_lines = 1;
    cycle(s, 1'b0);
    check("sat_1021", 64'(outstanding[4]), CNT_EN ? 64'd1021 : 64'd0);
    check("sat_pre_err", 64'(err_cnt), 64'd0);
    s = idle(); s.rd_v = 1'b1; s.rd_idx = 4; s.rd_lines = 4;
    cycle(s, 1'b0);
    check("sat_clamp", 64'(outstanding[4]), CNT_EN ? 64'(CNT_MAX) : 64'd0);
    check("sat_err", 64'(err_cnt), 64'(CNT_EN));

    // Underflow on an idle port.
    do_reset();
    cycle(ev_c0(K_RSP, 1, 12'h042, 9'h0), 1'b0);
    check("underflow_cnt", 64'(outstanding[1]), 64'd0);
    check("underflow_err", 64'(err_cnt), 64'(CNT_EN));

    // Reset with lines outstanding and a response in flight; a late response then underflows.
    do_reset();
    s = idle(); s.rd_v = 1'b1; s.rd_idx = 0; s.rd_lines = 4;
    cycle(s, 1'b0);
    s = idle(); s.rd_v = 1'b1; s.rd_idx = 0; s.rd_lines = 3;
    cycle(s, 1'b0);
    check("midflight_7", 64'(outstanding[0]), CNT_EN ? 64'd7 : 64'd0);
    cycle(ev_c0(K_RSP, 0, 12'h0EE, 9'h0), 1'b1);
    check("midflight_valid", 64'(afu_RxPort[0].c0.rspValid), 64'd0);
    check("midflight_cnt", 64'(outstanding[0]), 64'd0);
    check("midflight_err", 64'(err_cnt), 64'd0);
    cycle(ev_c0(K_RSP, 0, 12'h0EF, 9'h0), 1'b0);
    check("late_rsp_err", 64'(err_cnt), 64'(CNT_EN));

    // Directed routing table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].in, 1'b0);
      check($sformatf("tbl%0d_route", i), 64'(route_code()),
            tbl[i].port < 0 ? 64'd255 : 64'(tbl[i].chan*16 + tbl[i].port));
      if (tbl[i].port >= 0) begin
        mh = t_ccip_c0_ReqMmioHdr'(afu_RxPort[tbl[i].port].c0.hdr);
        case (tbl[i].chan)
          0:       fld = afu_RxPort[tbl[i].port].c0.hdr.mdata;
          3:       fld = afu_RxPort[tbl[i].port].c1.hdr.mdata;
          default: fld = mh.address;
        endcase
        check($sformatf("tbl%0d_field", i), 64'(fld), 64'(tbl[i].field));
      end
      check($sformatf("tbl%0d_unmapped", i), 64'(err_unmapped), 64'(tbl[i].unmapped));
    end

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.c0_kind = $urandom_range(0, 3);
      s.c0_idx  = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      s.c0_low  = 12'($urandom());
      s.c1_v    = 1'($urandom());
      s.c1_idx  = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      s.c1_low  = 12'($urandom());
      s.c1_fmt  = 1'($urandom());
      s.c1_cl   = $urandom_range(0, 3);
      s.alm0    = 1'($urandom());
      s.alm1    = 1'($urandom());
      s.rd_v    = 1'($urandom());
      s.rd_idx  = $urandom_range(0, 9);
      s.rd_lines = $urandom_range(1, 4);
      s.wr_v    = 1'($urandom());
      s.wr_idx  = $urandom_range(0, 9);
      s.wr_lines = $urandom_range(1, 4);
      cycle(s, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
